// File: rtl/usb_host_boot_timeout.sv
// ----------------------------------------------------------------------------
// usb_host_boot_timeout
//
// Bootloader supervisor running beside the USB protocol engine. It decides
// whether a USB host is present, qualifies SE0 bus resets, and raises the
// sticky BOOT request for the warm-boot primitive. The warm boot happens either
// because the SPI bridge endpoint asks for it or because no host appeared in
// time.
//
// Optional feature (macro USB_BOOT_TIMEOUT_EN):
//   defined   - the WAIT_HOST timeout (auto-boot) and the HOST_ACTIVE SOF-loss
//               fallback to WAIT_HOST are built in.
//   undefined - no timer or gap counter exists; boot happens only on
//               host_boot_req and HOST_ACTIVE is left only by booting.
//
// Parameters:
//   SE0_RESET_CYCLES    - synchronized SE0 cycles that qualify a bus reset
//   BOOT_TIMEOUT_CYCLES - cycles in WAIT_HOST without host activity before boot
//   SOF_LOSS_CYCLES     - cycles in HOST_ACTIVE without activity before the
//                         host is declared lost
//
// Ports:
//   clk                 in   48 MHz USB clock
//   reset               in   asynchronous active-low reset (0 = in reset)
//   usb_dp_in           in   raw D+ pad input (asynchronous)
//   usb_dn_in           in   raw D- pad input (asynchronous)
//   sof_valid           in   one-cycle pulse per valid start-of-frame
//   host_boot_req       in   one-cycle boot request from the SPI bridge
//   usb_bus_reset       out  high while a qualified SE0 bus reset is seen
//   host_present        out  high while in HOST_ACTIVE
//   boot_to_user_design out  sticky boot request, cleared only by reset
// ----------------------------------------------------------------------------
module usb_host_boot_timeout #(
    parameter int unsigned SE0_RESET_CYCLES    = 120,
    parameter int unsigned BOOT_TIMEOUT_CYCLES = 96000000,
    parameter int unsigned SOF_LOSS_CYCLES     = 144000
) (
    input  logic clk,
    input  logic reset,
    input  logic usb_dp_in,
    input  logic usb_dn_in,
    input  logic sof_valid,
    input  logic host_boot_req,
    output logic usb_bus_reset,
    output logic host_present,
    output logic boot_to_user_design
);

    // Elaboration-time sanity check of the cycle counts.
    if (SE0_RESET_CYCLES < 1 || BOOT_TIMEOUT_CYCLES < 2 || SOF_LOSS_CYCLES < 2)
    begin : g_bad_params
        $error("usb_host_boot_timeout: cycle-count parameters out of range");
    end

    localparam int unsigned Se0W = $clog2(SE0_RESET_CYCLES) + 1;
    localparam logic [Se0W-1:0] Se0Max = Se0W'(SE0_RESET_CYCLES);

    // ------------------------------------------------------------------------
    // Line synchronizers. Reset to 1 so an idle (J-state-safe) bus is assumed
    // until real samples arrive; that keeps a spurious SE0 out of reset.
    // ------------------------------------------------------------------------
    logic r_dp_meta;
    logic r_dp_sync;
    logic r_dn_meta;
    logic r_dn_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dp_meta <= 1'b1;
            r_dp_sync <= 1'b1;
            r_dn_meta <= 1'b1;
            r_dn_sync <= 1'b1;
        end else begin
            r_dp_meta <= usb_dp_in;
            r_dp_sync <= r_dp_meta;
            r_dn_meta <= usb_dn_in;
            r_dn_sync <= r_dn_meta;
        end
    end

    logic w_se0;
    assign w_se0 = ~r_dp_sync & ~r_dn_sync;

    // ------------------------------------------------------------------------
    // SE0 qualification. The counter saturates so a long reset holds
    // usb_bus_reset steadily; the flag is raised on the same edge the count
    // reaches the threshold and dropped on the first edge that sees no SE0.
    // ------------------------------------------------------------------------
    logic [Se0W-1:0] r_se0_cnt;
    logic [Se0W-1:0] w_se0_cnt_d;
    logic            r_bus_reset;

    always_comb begin
        w_se0_cnt_d = '0;
        if (w_se0) begin
            if (r_se0_cnt == Se0Max) begin
                w_se0_cnt_d = r_se0_cnt;
            end else begin
                w_se0_cnt_d = r_se0_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_se0_cnt   <= '0;
            r_bus_reset <= 1'b0;
        end else begin
            r_se0_cnt   <= w_se0_cnt_d;
            r_bus_reset <= w_se0 && (w_se0_cnt_d == Se0Max);
        end
    end

    assign usb_bus_reset = r_bus_reset;

    logic w_host_activity;
    assign w_host_activity = sof_valid | r_bus_reset;

    // ------------------------------------------------------------------------
    // State definitions.
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        StWaitHost   = 2'd0,
        StHostActive = 2'd1,
        StBooting    = 2'd2
    } state_e;

    state_e r_state;

    // ------------------------------------------------------------------------
    // Timeout and SOF-loss counters (optional). Each counter runs only in its
    // own state and is held at zero everywhere else, so entering a state
    // always starts a fresh count without an explicit clear on the transition.
    // ------------------------------------------------------------------------
    logic w_timeout;
    logic w_sof_loss;

`ifdef USB_BOOT_TIMEOUT_EN
    localparam int unsigned TmrW = $clog2(BOOT_TIMEOUT_CYCLES) + 1;
    localparam int unsigned GapW = $clog2(SOF_LOSS_CYCLES) + 1;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(BOOT_TIMEOUT_CYCLES - 1);
    localparam logic [GapW-1:0] GapLast = GapW'(SOF_LOSS_CYCLES - 1);

    logic [TmrW-1:0] r_timer;
    logic [GapW-1:0] r_gap;

    assign w_timeout  = (r_timer == TmrLast);
    assign w_sof_loss = (r_gap == GapLast);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
            r_gap   <= '0;
        end else begin
            if (r_state == StWaitHost && !w_host_activity && !host_boot_req &&
                !w_timeout) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end

            if (r_state == StHostActive && !w_host_activity && !host_boot_req &&
                !w_sof_loss) begin
                r_gap <= r_gap + 1'b1;
            end else begin
                r_gap <= '0;
            end
        end
    end
`else
    assign w_timeout  = 1'b0;
    assign w_sof_loss = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Supervisor FSM with registered outputs. Outputs are written on the same
    // edge as the state change so they are valid in the first cycle of the
    // new state. host_boot_req beats everything; in WAIT_HOST, activity beats
    // a simultaneous timeout.
    // ------------------------------------------------------------------------
    logic r_host_present;
    logic r_boot;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= StWaitHost;
            r_host_present <= 1'b0;
            r_boot         <= 1'b0;
        end else begin
            case (r_state)
                StWaitHost: begin
                    if (host_boot_req) begin
                        r_state        <= StBooting;
                        r_host_present <= 1'b0;
                        r_boot         <= 1'b1;
                    end else if (w_host_activity) begin
                        r_state        <= StHostActive;
                        r_host_present <= 1'b1;
                    end else if (w_timeout) begin
                        r_state        <= StBooting;
                        r_host_present <= 1'b0;
                        r_boot         <= 1'b1;
                    end
                end
                StHostActive: begin
                    if (host_boot_req) begin
                        r_state        <= StBooting;
                        r_host_present <= 1'b0;
                        r_boot         <= 1'b1;
                    end else if (!w_host_activity && w_sof_loss) begin
                        r_state        <= StWaitHost;
                        r_host_present <= 1'b0;
                    end
                end
                StBooting: begin
                    // Terminal: only reset leaves this state.
                    r_host_present <= 1'b0;
                    r_boot         <= 1'b1;
                end
                default: begin
                    r_state        <= StWaitHost;
                    r_host_present <= 1'b0;
                    r_boot         <= 1'b0;
                end
            endcase
        end
    end

    assign host_present        = r_host_present;
    assign boot_to_user_design = r_boot;

endmodule

// File: tb/tb_usb_host_boot_timeout.sv
// ----------------------------------------------------------------------------
// Testbench for usb_host_boot_timeout with SE0_RESET_CYCLES=8,
// BOOT_TIMEOUT_CYCLES=100, SOF_LOSS_CYCLES=20. Works with or without
// USB_BOOT_TIMEOUT_EN. A behavioural model based on elapsed-cycle arithmetic
// checks every cycle; a vector table and hand sequences check the corners.
// ----------------------------------------------------------------------------
module tb_usb_host_boot_timeout;

    localparam int Se0N  = 8;
    localparam int BootN = 100;
    localparam int LossN = 20;
`ifdef USB_BOOT_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic dp    = 1'b1;
    logic dn    = 1'b0;
    logic sof   = 1'b0;
    logic req   = 1'b0;
    logic bus_rst;
    logic host;
    logic boot;

    usb_host_boot_timeout #(
        .SE0_RESET_CYCLES   (Se0N),
        .BOOT_TIMEOUT_CYCLES(BootN),
        .SOF_LOSS_CYCLES    (LossN)
    ) u_dut (
        .clk                (clk),
        .reset              (reset),
        .usb_dp_in          (dp),
        .usb_dn_in          (dn),
        .sof_valid          (sof),
        .host_boot_req      (req),
        .usb_bus_reset      (bus_rst),
        .host_present       (host),
        .boot_to_user_design(boot)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    // Mode is tracked by name; time is tracked as edges since reset release.
    localparam int MWait   = 0;
    localparam int MActive = 1;
    localparam int MBoot   = 2;

    int m_edge;
    int m_mode;
    int m_wait_start;   // edge at which the current wait began
    int m_last_act;     // edge of the most recent host activity
    int m_run;          // consecutive SE0 cycles seen after synchronisation
    bit m_raw_q[$];     // raw SE0 levels of the two previous edges
    bit m_bus;
    bit m_host;
    bit m_boot;

    function automatic void model_reset();
        m_edge       = 0;
        m_mode       = MWait;
        m_wait_start = 0;
        m_last_act   = 0;
        m_run        = 0;
        m_raw_q.delete();
        m_raw_q.push_back(1'b0);
        m_raw_q.push_back(1'b0);
        m_bus  = 1'b0;
        m_host = 1'b0;
        m_boot = 1'b0;
    endfunction

    function automatic void model_step(input bit raw_se0, input bit sof_v, input bit req_v);
        bit sampled;
        bit act;
        m_edge  = m_edge + 1;
        sampled = m_raw_q.pop_front();  // line level two edges ago
        m_raw_q.push_back(raw_se0);
        act = sof_v | m_bus;
        if (req_v) begin
            m_mode = MBoot;
        end else if (m_mode == MWait) begin
            if (act) begin
                m_mode     = MActive;
                m_last_act = m_edge;
            end else if (TimeoutEn && (m_edge - m_wait_start == BootN)) begin
                m_mode = MBoot;
            end
        end else if (m_mode == MActive) begin
            if (act) begin
                m_last_act = m_edge;
            end else if (TimeoutEn && (m_edge - m_last_act == LossN)) begin
                m_mode       = MWait;
                m_wait_start = m_edge;
            end
        end
        m_run  = sampled ? m_run + 1 : 0;
        m_bus  = (m_run >= Se0N);
        m_host = (m_mode == MActive);
        m_boot = (m_mode == MBoot);
    endfunction

    // ---------------- checking helpers ----------------
    function automatic void check_bit(input string name, input logic got, input logic exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic void check_out(input string name, input logic [2:0] exp);
        n_checks = n_checks + 1;
        if ({bus_rst, host, boot} !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: bus_reset/host_present/boot got %b, required %b (t=%0t)",
                     name, {bus_rst, host, boot}, exp, $time);
        end
    endfunction

    // Apply sof/req for one clock (lines keep their current levels), then
    // compare against the model half a cycle after the edge.
    task automatic tick(input logic sof_v, input logic req_v);
        sof = sof_v;
        req = req_v;
        model_step(!dp && !dn, sof_v, req_v);
        @(posedge clk);
        @(negedge clk);
        check_out("model", {m_bus, m_host, m_boot});
        sof = 1'b0;
        req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    // Reset asserted on a falling edge; outputs must clear without a clock.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        dp    = 1'b1;
        dn    = 1'b0;
        sof   = 1'b0;
        req   = 1'b0;
        #1;
        check_out("async_reset", 3'b000);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit    dp;
        bit    dn;
        bit    sof;
        bit    req;
        int    cycles;
        bit    e_bus;
        bit    e_host;
        bit    e_boot;
        string name;
    } vec_t;

    function automatic vec_t mk(input bit dp_v, input bit dn_v, input bit sof_v, input bit req_v,
                                input int cyc, input bit eb, input bit eh, input bit ebt,
                                input string nm);
        vec_t v;
        v.dp = dp_v; v.dn = dn_v; v.sof = sof_v; v.req = req_v; v.cycles = cyc;
        v.e_bus = eb; v.e_host = eh; v.e_boot = ebt; v.name = nm;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        int burst;
        int sof_div[4];

        // sof/req apply only to the first cycle of a row; expectations hold
        // at the end of the row.
        vecs[0]  = mk(1, 0, 0, 0, 5, 0, 0, 0, "idle_j");
        vecs[1]  = mk(0, 0, 0, 0, 7, 0, 0, 0, "se0_7_short");
        vecs[2]  = mk(1, 0, 0, 0, 5, 0, 0, 0, "short_se0_no_pulse");
        vecs[3]  = mk(0, 0, 0, 0, 9, 0, 0, 0, "se0_before_qual");
        vecs[4]  = mk(0, 0, 0, 0, 1, 1, 0, 0, "bus_reset_rise");
        vecs[5]  = mk(0, 0, 0, 0, 1, 1, 1, 0, "host_from_bus_reset");
        vecs[6]  = mk(1, 0, 0, 0, 2, 1, 1, 0, "bus_reset_sync_tail");
        vecs[7]  = mk(1, 0, 0, 0, 1, 0, 1, 0, "bus_reset_fall");
        vecs[8]  = mk(1, 0, 0, 0, 19, 0, 1, 0, "gap_not_yet_lost");
        vecs[9]  = mk(1, 0, 0, 0, 1, 0, !TimeoutEn, 0, "sof_loss_edge");
        vecs[10] = mk(1, 0, 1, 0, 1, 0, 1, 0, "sof_reacquire");
        vecs[11] = mk(1, 0, 1, 1, 1, 0, 0, 1, "req_beats_sof");
        vecs[12] = mk(1, 0, 0, 0, 3, 0, 0, 1, "boot_sticky");

        apply_reset();
        for (int v = 0; v < 13; v++) begin
            dp = vecs[v].dp;
            dn = vecs[v].dn;
            for (int c = 0; c < vecs[v].cycles; c++) begin
                tick((c == 0) ? vecs[v].sof : 1'b0, (c == 0) ? vecs[v].req : 1'b0);
            end
            check_out(vecs[v].name, {vecs[v].e_bus, vecs[v].e_host, vecs[v].e_boot});
        end

        // Reset out of BOOTING, then the timeout runs from zero again.
        apply_reset();
        idle(BootN - 1);
        check_bit("boot_before_timeout", boot, 1'b0);
        check_bit("host_while_waiting", host, 1'b0);
        tick(1'b0, 1'b0);
        check_bit("boot_at_timeout", boot, TimeoutEn);
        idle(500);
        check_bit("boot_stays", boot, TimeoutEn);
        check_bit("host_never", host, 1'b0);

        // SOF every 15 cycles from cycle 10 through cycle 1000, then silence.
        apply_reset();
        for (int c = 1; c <= 1000; c++) begin
            tick((c >= 10) && ((c - 10) % 15 == 0), 1'b0);
        end
        check_bit("host_with_sof", host, 1'b1);
        check_bit("no_boot_with_sof", boot, 1'b0);
        idle(LossN - 1);
        check_bit("host_before_loss", host, 1'b1);
        tick(1'b0, 1'b0);
        check_bit("host_after_loss", host, !TimeoutEn);
        idle(BootN - 1);
        check_bit("boot_before_retimeout", boot, 1'b0);
        tick(1'b0, 1'b0);
        check_bit("boot_after_retimeout", boot, TimeoutEn);

        // SOF in the very cycle the timeout would expire.
        apply_reset();
        idle(BootN - 1);
        tick(1'b1, 1'b0);
        check_bit("sof_vs_timeout_host", host, 1'b1);
        check_bit("sof_vs_timeout_boot", boot, 1'b0);

        // Randomised segments with differing SOF density.
        sof_div[0] = 6;
        sof_div[1] = 25;
        sof_div[2] = 60;
        sof_div[3] = 5000;
        for (int s = 0; s < 4; s++) begin
            apply_reset();
            burst = 0;
            for (int c = 0; c < 2500; c++) begin
                int r;
                if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(1, 14);
                if (burst > 0) begin
                    dp = 1'b0;
                    dn = 1'b0;
                    burst = burst - 1;
                end else begin
                    r = $urandom_range(0, 9);
                    dp = (r != 8);
                    dn = (r >= 8);
                end
                tick($urandom_range(0, sof_div[s] - 1) == 0, $urandom_range(0, 1999) == 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
